// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the 5-stage MIPS pipeline: data-memory access with stall and
// timeout abort, plus the MEM/WB register that feeds register-file writeback.
module mem_wb_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_mem,
    input  logic             regwrite_mem,
    input  logic             memtoreg_mem,
    input  logic             memwrite_mem,
    input  logic [WIDTH-1:0] aluout_mem,
    input  logic [WIDTH-1:0] writedata_mem,
    input  logic [4:0]       writereg_mem,
    output logic             stall_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             regwrite_wb,
    output logic [4:0]       regaddr_wb,
    output logic [WIDTH-1:0] result_wb,
    output logic             valid_wb,
    output logic             err_wb,
    output logic             o_dbg_state,
    output logic [7:0]       o_dbg_wcnt
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t           r_state;
    logic [7:0]       r_wcnt;
    logic             r_valid_wb;
    logic             r_regwrite_wb;
    logic [4:0]       r_regaddr_wb;
    logic [WIDTH-1:0] r_result_wb;
    logic             r_err_wb;

    logic w_memop;
    logic w_misal;
    logic w_aligned_op;
    logic w_in_wait;
    logic w_abort;
    logic w_req;
    logic w_retire;
    logic w_error;

    // Bus handshake: dmem_req is held with addr/we/wdata stable until the cycle
    // in which dmem_ack pulses; that cycle completes the transfer and dmem_rdata
    // is valid only then. An ack with no request outstanding is ignored.
    always_comb begin
        w_memop      = valid_mem & (memtoreg_mem | memwrite_mem);
        w_misal      = (aluout_mem[1:0] != 2'b00);
        w_aligned_op = w_memop & ~w_misal;
        w_in_wait    = (r_state == S_WAIT);
        w_abort      = w_in_wait & ~dmem_ack & (r_wcnt == LP_TIMEOUT);
        w_req        = rst & (w_in_wait ? ~w_abort : w_aligned_op);
        w_retire     = w_in_wait ? (dmem_ack | w_abort) : (~w_aligned_op | dmem_ack);
        w_error      = w_abort | (~w_in_wait & w_memop & w_misal);
    end

    assign dmem_req    = w_req;
    assign dmem_we     = w_req & memwrite_mem;
    assign dmem_addr   = w_req ? aluout_mem : '0;
    assign dmem_wdata  = w_req ? writedata_mem : '0;
    assign stall_mem   = w_req & ~dmem_ack;

    assign regwrite_wb = r_regwrite_wb;
    assign regaddr_wb  = r_regaddr_wb;
    assign result_wb   = r_result_wb;
    assign valid_wb    = r_valid_wb;
    assign err_wb      = r_err_wb;
    assign o_dbg_state = r_state;
    assign o_dbg_wcnt  = r_wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wcnt        <= 8'd0;
            r_valid_wb    <= 1'b0;
            r_regwrite_wb <= 1'b0;
            r_regaddr_wb  <= 5'd0;
            r_result_wb   <= '0;
            r_err_wb      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aligned_op && !dmem_ack) begin
                        r_state <= S_WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack || w_abort) begin
                        r_state <= S_IDLE;
                        r_wcnt  <= 8'd0;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wcnt  <= 8'd0;
                end
            endcase

            // Non-retire edges insert a bubble but keep address/data for a stable bus.
            if (w_retire) begin
                r_valid_wb    <= valid_mem;
                r_regwrite_wb <= valid_mem & regwrite_mem & ~w_error & (writereg_mem != 5'd0);
                r_regaddr_wb  <= writereg_mem;
                r_result_wb   <= memtoreg_mem ? dmem_rdata : aluout_mem;
                r_err_wb      <= w_error;
            end else begin
                r_valid_wb    <= 1'b0;
                r_regwrite_wb <= 1'b0;
                r_err_wb      <= 1'b0;
            end
        end
    end

endmodule
